mux2: RTL and testbench
=======================

MUX2 -- requirements
Module: mux2

Interface
REQ-001 Parameter WIDTH, default 1, data width of A, B, OUT and OUT_Q; legal range 1-64.
REQ-002 Parameter CNT_W, default 8, width of SEL_CHG.
REQ-003 The clock SHALL be named clk, a 1-bit input; all state updates on its rising edge; the block has one clock.
REQ-004 The reset SHALL be named rst, a 1-bit input; reset is synchronous and active-high.
REQ-005 A, input, WIDTH: data input selected when SEL=0.
REQ-006 B, input, WIDTH: data input selected when SEL=1.
REQ-007 SEL, input, 1: select line.
REQ-008 EN, input, 1: register-update enable for OUT_Q and VALID.
REQ-009 OUT, output, WIDTH: combinational mux result.
REQ-010 OUT_Q, output, WIDTH: registered mux result.
REQ-011 VALID, output, 1: OUT_Q holds a captured value since the last reset.
REQ-012 SEL_CHG, output, CNT_W: saturating count of SEL transitions sampled at clk.

Function
REQ-013 OUT SHALL equal A when SEL=0 and B when SEL=1, purely combinational, with zero clock latency and no dependence on clk, rst or EN.
REQ-014 OUT SHALL update within the same simulation time step as any change on A, B or SEL, with no inferred latch.
REQ-015 If SEL is X or Z, OUT bits SHALL be X wherever the A and B bits differ, and SHALL equal the common bit wherever they agree.
REQ-016 On a rising clk edge with rst=0 and EN=1, OUT_Q SHALL load the current OUT value and VALID SHALL go to 1.
REQ-017 On a rising clk edge with rst=0 and EN=0, OUT_Q and VALID SHALL hold their values.
REQ-018 OUT_Q latency SHALL be exactly one clk cycle from the edge at which the inputs are sampled.
REQ-019 The block SHALL hold a 1-bit register sel_d that samples SEL on every rising edge, independent of EN.
REQ-020 SEL_CHG SHALL increment by 1 on each edge where SEL differs from sel_d, independent of EN.
REQ-021 SEL_CHG SHALL saturate at 2^CNT_W-1 and never wrap to 0.
REQ-022 The first edge after reset SHALL NOT count as a transition; sel_d is primed from SEL on that edge.
REQ-023 Simultaneous changes on A or B with an unchanged SEL SHALL NOT increment SEL_CHG.

Reset
REQ-024 While rst=1 at a rising edge, OUT_Q SHALL be 0, VALID SHALL be 0, SEL_CHG SHALL be 0, and the sel_d primed flag SHALL be cleared.
REQ-025 rst SHALL take priority over EN.
REQ-026 Asserting rst mid-operation SHALL clear the registered state at the next edge only; OUT stays combinational throughout reset.
REQ-027 Before the first clk edge, registered outputs are undefined; the bench SHALL apply reset for at least 1 cycle.

Verification
REQ-028 Exhaustive 1-bit sweep: apply each (A,B,SEL) combination from 000 to 111 for 10 time units each -> OUT = 0,0,0,1,1,0,1,1 in that order.
REQ-029 Registered path: rst for 2 cycles, then EN=1, A=1, B=0, SEL=0 -> OUT_Q=1 and VALID=1 one edge later; next SEL=1 -> OUT_Q=0 one edge later.
REQ-030 Enable hold: with OUT_Q=1, drop EN to 0 and change SEL -> OUT follows SEL immediately, OUT_Q stays 1.
REQ-031 Counter: after reset, toggle SEL every cycle for 10 cycles -> SEL_CHG=9; with CNT_W=3, 20 toggles -> SEL_CHG=7 (saturated).
REQ-032 Reset mid-run: with VALID=1 and SEL_CHG=5, assert rst for one edge while EN=1 -> OUT_Q=0, VALID=0 and SEL_CHG=0 after that edge, while OUT still tracks its inputs.
REQ-033 WIDTH=8: A=0xA5, B=0x3C; SEL=0 gives OUT=0xA5 and SEL=1 gives OUT=0x3C; SEL=X gives OUT bits that agree equal to A and B, and X elsewhere.

Source files
------------

// File: rtl/mux2_if.sv
// rtl/mux2_if.sv - data, select and status bundle for the mux2 block
interface mux2_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic             en;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             valid;
  logic [CNT_W-1:0] sel_chg;

  modport master (
    output a, b, sel, en,
    input  out, out_q, valid, sel_chg
  );

  modport slave (
    input  a, b, sel, en,
    output out, out_q, valid, sel_chg
  );
endinterface

// File: rtl/mux2.sv
// rtl/mux2.sv - 2:1 mux with registered copy and saturating select-change counter
module mux2 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input logic   clk,
  input logic   rst,
  mux2_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] mux_d;
  logic [WIDTH-1:0] out_q_r;
  logic             valid_r;
  logic [CNT_W-1:0] sel_chg_r;
  logic             sel_d;
  logic             primed;

  // ?: keeps agreeing bits and yields X only where a and b differ when sel is unknown
  assign mux_d = bus.sel ? bus.b : bus.a;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q_r <= '0;
      valid_r <= 1'b0;
    end else if (bus.en) begin
      out_q_r <= mux_d;
      valid_r <= 1'b1;
    end
  end

  // first edge after reset only primes sel_d so it never counts as a transition
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_chg_r <= '0;
      primed    <= 1'b0;
      sel_d     <= 1'b0;
    end else begin
      sel_d  <= bus.sel;
      primed <= 1'b1;
      if (primed && (bus.sel != sel_d) && (sel_chg_r != CNT_MAX))
        sel_chg_r <= sel_chg_r + 1'b1;
    end
  end

  assign bus.out     = mux_d;
  assign bus.out_q   = out_q_r;
  assign bus.valid   = valid_r;
  assign bus.sel_chg = sel_chg_r;
endmodule

// File: tb/tb_mux2.sv
// tb/tb_mux2.sv - directed checks of mux2 at WIDTH=1/CNT_W=8 and WIDTH=8/CNT_W=3
module tb_mux2;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  mux2_if #(.WIDTH(1), .CNT_W(8)) ifa ();
  mux2_if #(.WIDTH(8), .CNT_W(3)) ifb ();

  mux2 #(.WIDTH(1), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  mux2 #(.WIDTH(8), .CNT_W(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] vec;
  logic [7:0] sweep_exp;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ifa.a = 1'b0; ifa.b = 1'b0; ifa.sel = 1'b0; ifa.en = 1'b0;
    ifb.a = 8'h00; ifb.b = 8'h00; ifb.sel = 1'b0; ifb.en = 1'b0;

    // combinational sweep over {a,b,sel}
    sweep_exp = 8'b1101_1000;
    for (int i = 0; i < 8; i++) begin
      vec = 3'(i);
      ifa.a = vec[2]; ifa.b = vec[1]; ifa.sel = vec[0];
      #1;
      check($sformatf("sweep%0d", i), 64'(ifa.out), 64'(sweep_exp[i]));
      #9;
    end

    // registered path
    rst = 1'b1;
    tick();
    tick();
    check("rst_out_q", 64'(ifa.out_q), 64'd0);
    check("rst_valid", 64'(ifa.valid), 64'd0);
    check("rst_selchg", 64'(ifa.sel_chg), 64'd0);
    rst = 1'b0;
    ifa.en = 1'b1; ifa.a = 1'b1; ifa.b = 1'b0; ifa.sel = 1'b0;
    #1;
    check("pre_valid", 64'(ifa.valid), 64'd0);
    tick();
    check("cap_out_q", 64'(ifa.out_q), 64'd1);
    check("cap_valid", 64'(ifa.valid), 64'd1);
    check("prime_nocount", 64'(ifa.sel_chg), 64'd0);
    ifa.sel = 1'b1;
    tick();
    check("sel1_out_q", 64'(ifa.out_q), 64'd0);
    check("sel1_chg", 64'(ifa.sel_chg), 64'd1);
    ifa.sel = 1'b0;
    tick();
    check("sel0_out_q", 64'(ifa.out_q), 64'd1);

    // enable hold
    ifa.en = 1'b0;
    ifa.sel = 1'b1;
    #1;
    check("hold_out_comb", 64'(ifa.out), 64'd0);
    tick();
    check("hold_out_q", 64'(ifa.out_q), 64'd1);
    check("hold_valid", 64'(ifa.valid), 64'd1);
    check("hold_chg_counts", 64'(ifa.sel_chg), 64'd3);
    ifa.a = 1'b0; ifa.b = 1'b0;
    tick();
    check("data_no_count", 64'(ifa.sel_chg), 64'd3);

    // counters: 10 toggles on 8-bit counter, 20 toggles on 3-bit counter
    rst = 1'b1;
    ifa.en = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ifa.sel = i[0];
      ifb.sel = i[0];
      tick();
      if (i == 9) check("cnt10", 64'(ifa.sel_chg), 64'd9);
    end
    check("cnt20", 64'(ifa.sel_chg), 64'd19);
    check("cnt_sat", 64'(ifb.sel_chg), 64'd7);
    ifb.sel = ~ifb.sel;
    tick();
    check("cnt_sat_hold", 64'(ifb.sel_chg), 64'd7);

    // reset mid-run with valid=1 and sel_chg=5
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifa.en = 1'b1; ifa.a = 1'b1; ifa.b = 1'b0; ifa.sel = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      ifa.sel = ~ifa.sel;
      tick();
    end
    check("mid_pre_chg", 64'(ifa.sel_chg), 64'd5);
    check("mid_pre_valid", 64'(ifa.valid), 64'd1);
    rst = 1'b1;
    ifa.sel = 1'b0;
    tick();
    check("mid_out_q", 64'(ifa.out_q), 64'd0);
    check("mid_valid", 64'(ifa.valid), 64'd0);
    check("mid_chg", 64'(ifa.sel_chg), 64'd0);
    check("mid_out_comb", 64'(ifa.out), 64'd1);
    ifa.a = 1'b0;
    #1;
    check("mid_out_track", 64'(ifa.out), 64'd0);
    rst = 1'b0;

    // 8-bit data path
    ifb.a = 8'hA5; ifb.b = 8'h3C; ifb.sel = 1'b0;
    #1;
    check("w8_sel0", 64'(ifb.out), 64'hA5);
    ifb.sel = 1'b1;
    #1;
    check("w8_sel1", 64'(ifb.out), 64'h3C);
    ifb.sel = 1'bx;
    #1;
    check("w8_selx_agree", 64'(ifb.out & 8'h66), 64'h24);
    ifb.sel = 1'b0;
    ifb.en = 1'b1;
    tick();
    check("w8_out_q", 64'(ifb.out_q), 64'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
